// File: rtl/stage2_race.sv
// Second game-engine stage: accepts a stage-1 verdict, runs a ROUNDS-long race, holds a registered verdict.
// Optional feature: define STAGE2_STREAK_EN to add +2 to a hi==7 round that follows another hi==7 round.
module stage2_race #(
  parameter int ROUNDS = 4,
  parameter int THRESH = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       pass1,
  input  logic [1:0] bonus1,
  input  logic [6:0] random2,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       pass2,
  output logic [7:0] score,
  output logic [1:0] bonus2
);

  // Handshake: a transfer happens on a rising edge where valid && ready; in_ready is high only
  // in IDLE, out_valid only in DONE, and the verdict stays stable until out_ready is seen.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [8:0] TH0  = 9'(THRESH);
  localparam logic [8:0] TH8  = 9'(THRESH + 8);
  localparam logic [8:0] TH16 = 9'(THRESH + 16);
  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t     state_q, state_d;
  logic [1:0] bonus1_q, bonus1_d;
  logic [7:0] score_q, score_d;
  logic [3:0] rnd_q, rnd_d;
  logic       pass2_q, pass2_d;
  logic [1:0] bonus2_q, bonus2_d;

  logic [2:0] hi;
  logic       stumble;
  logic [4:0] raw_step;
  logic [4:0] step;
  logic [4:0] step_fin;
  logic [8:0] sum;
  logic       unused_rand;

  assign hi          = random2[6:4];
  assign stumble     = random2[0];
  assign unused_rand = ^random2[3:1];
  assign raw_step    = {2'b00, hi} + {3'b000, bonus1_q};
  // Floor at zero: the stumble only subtracts when there is something to subtract from.
  assign step        = (raw_step > {4'b0000, stumble}) ? (raw_step - {4'b0000, stumble}) : 5'd0;

`ifdef STAGE2_STREAK_EN
  logic streak_q, streak_d;
  assign step_fin = step + ((streak_q && (hi == 3'd7)) ? 5'd2 : 5'd0);
`else
  assign step_fin = step;
`endif

  assign sum = {1'b0, score_q} + {4'b0000, step_fin};

  always_comb begin
    state_d  = state_q;
    bonus1_d = bonus1_q;
    score_d  = score_q;
    rnd_d    = rnd_q;
    pass2_d  = pass2_q;
    bonus2_d = bonus2_q;
`ifdef STAGE2_STREAK_EN
    streak_d = streak_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          bonus1_d = bonus1;
          score_d  = 8'd0;
          rnd_d    = 4'd0;
          pass2_d  = 1'b0;
          bonus2_d = 2'd0;
`ifdef STAGE2_STREAK_EN
          streak_d = 1'b0;
`endif
          state_d  = pass1 ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        score_d = sum[8] ? 8'd255 : sum[7:0];
        rnd_d   = rnd_q + 4'd1;
`ifdef STAGE2_STREAK_EN
        streak_d = (hi == 3'd7);
`endif
        if (rnd_q == LAST) begin
          state_d = S_DONE;
          pass2_d = ({1'b0, score_d} >= TH0);
          if ({1'b0, score_d} >= TH16)     bonus2_d = 2'd3;
          else if ({1'b0, score_d} >= TH8) bonus2_d = 2'd2;
          else if ({1'b0, score_d} >= TH0) bonus2_d = 2'd1;
          else                             bonus2_d = 2'd0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bonus1_q <= 2'd0;
      score_q  <= 8'd0;
      rnd_q    <= 4'd0;
      pass2_q  <= 1'b0;
      bonus2_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      bonus1_q <= bonus1_d;
      score_q  <= score_d;
      rnd_q    <= rnd_d;
      pass2_q  <= pass2_d;
      bonus2_q <= bonus2_d;
    end
  end

`ifdef STAGE2_STREAK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak_q <= 1'b0;
    else     streak_q <= streak_d;
  end
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign pass2     = pass2_q;
  assign score     = score_q;
  assign bonus2    = bonus2_q;

endmodule

// File: tb/tb_stage2_race.sv
// Bench for stage2_race: constant vector table, hand sequences (back-pressure, reset mid-RUN)
// and randomized races checked against a round-by-round arithmetic model.
module tb_stage2_race;
  localparam int ROUNDS = 4;
  localparam int THRESH = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       pass1;
  logic [1:0] bonus1;
  logic [6:0] random2;
  logic       out_valid;
  logic       out_ready;
  logic       pass2;
  logic [7:0] score;
  logic [1:0] bonus2;

  int tests  = 0;
  int failed = 0;
  logic [10:0] exp_q[$];

  stage2_race #(.ROUNDS(ROUNDS), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pass1(pass1), .bonus1(bonus1), .random2(random2),
    .out_valid(out_valid), .out_ready(out_ready),
    .pass2(pass2), .score(score), .bonus2(bonus2)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                 p1;
    logic [1:0]         b1;
    logic [3:0][6:0]    r;
    int                 hold;
    logic [10:0]        exp;
  } vec_t;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Expected verdict {pass2, bonus2, score} from the race rules.
  function automatic logic [10:0] model(input bit p1, input int b1, input logic [3:0][6:0] r);
    int s = 0;
    int prev7 = 0;
    int step;
    int hi;
    int p;
    int g;
    if (!p1) return 11'd0;
    for (int i = 0; i < ROUNDS; i++) begin
      hi   = int'(r[i]) / 16;
      step = hi + b1 - (int'(r[i]) % 2);
      if (step < 0) step = 0;
`ifdef STAGE2_STREAK_EN
      if (prev7 != 0 && hi == 7) step += 2;
`endif
      prev7 = (hi == 7) ? 1 : 0;
      s = s + step;
      if (s > 255) s = 255;
    end
    p = (s >= THRESH) ? 1 : 0;
    g = (s >= THRESH + 16) ? 3 : (s >= THRESH + 8) ? 2 : (s >= THRESH) ? 1 : 0;
    return {1'(p), 2'(g), 8'(s)};
  endfunction

  task automatic do_txn(input bit p1, input logic [1:0] b1, input logic [3:0][6:0] r,
                        input int hold, input logic [10:0] exp, input string nm);
    int n;
    logic [10:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    check({nm, "_in_ready_idle"}, int'(in_ready), 1);
    in_valid = 1'b1; pass1 = p1; bonus1 = b1; random2 = 7'($urandom);
    @(negedge clk);
    in_valid = 1'b0; pass1 = 1'($urandom); bonus1 = 2'($urandom);
    n = 0;
    while (!out_valid && n <= 20) begin
      random2 = (n < ROUNDS) ? r[n] : 7'($urandom);
      @(negedge clk);
      n++;
    end
    check({nm, "_latency"}, n, p1 ? ROUNDS : 0);
    e = exp_q.pop_front();
    check({nm, "_score"},  int'(score),  int'(e[7:0]));
    check({nm, "_pass2"},  int'(pass2),  int'(e[10]));
    check({nm, "_bonus2"}, int'(bonus2), int'(e[9:8]));
    check({nm, "_in_ready_busy"}, int'(in_ready), 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1)); pass1 = 1'b1; bonus1 = 2'($urandom);
      random2 = 7'($urandom);
      @(negedge clk);
      check({nm, "_hold_valid"}, int'(out_valid), 1);
      check({nm, "_hold_ready"}, int'(in_ready), 0);
      check({nm, "_hold_out"}, int'({pass2, bonus2, score}), int'(e));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, "_post_in_ready"}, int'(in_ready), 1);
    check({nm, "_post_out_valid"}, int'(out_valid), 0);
    check({nm, "_post_kept"}, int'({pass2, bonus2, score}), int'(e));
  endtask

  vec_t vecs[6];
  logic [3:0][6:0] rr;
  logic [10:0] ex;
  bit p;
  logic [1:0] b;

  initial begin
`ifdef STAGE2_STREAK_EN
    vecs[0] = '{1'b1, 2'd2, {4{7'b1110000}}, 0, {1'b1, 2'd3, 8'd42}};
    vecs[5] = '{1'b1, 2'd3, {4{7'b1111111}}, 1, {1'b1, 2'd3, 8'd42}};
`else
    vecs[0] = '{1'b1, 2'd2, {4{7'b1110000}}, 0, {1'b1, 2'd3, 8'd36}};
    vecs[5] = '{1'b1, 2'd3, {4{7'b1111111}}, 1, {1'b1, 2'd3, 8'd36}};
`endif
    vecs[1] = '{1'b0, 2'd3, {4{7'b1110000}}, 0, 11'd0};
    vecs[2] = '{1'b1, 2'd0, {4{7'b0010001}}, 0, 11'd0};
    vecs[3] = '{1'b1, 2'd0, {4{7'b1010000}}, 0, {1'b1, 2'd1, 8'd20}};
    vecs[4] = '{1'b1, 2'd0, {7'b1010000, 7'b1010000, 7'b1010000, 7'b1000000}, 5,
                {1'b0, 2'd0, 8'd19}};

    rst = 1'b1; in_valid = 1'b0; pass1 = 1'b0; bonus1 = 2'd0; random2 = 7'd0; out_ready = 1'b0;
    @(negedge clk);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_outputs", int'({pass2, bonus2, score}), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      do_txn(vecs[i].p1, vecs[i].b1, vecs[i].r, vecs[i].hold, vecs[i].exp, $sformatf("vec%0d", i));

    // Reset in the middle of a race, then a clean full-length run.
    @(negedge clk);
    in_valid = 1'b1; pass1 = 1'b1; bonus1 = 2'd2;
    @(negedge clk);
    in_valid = 1'b0; random2 = 7'b1110000;
    @(negedge clk);
    @(negedge clk);
`ifdef STAGE2_STREAK_EN
    check("midrun_partial", int'(score), 20);
`else
    check("midrun_partial", int'(score), 18);
`endif
    #2 rst = 1'b1;
    #1;
    check("midrun_rst_in_ready", int'(in_ready), 1);
    check("midrun_rst_out_valid", int'(out_valid), 0);
    check("midrun_rst_outputs", int'({pass2, bonus2, score}), 0);
    @(negedge clk);
    rst = 1'b0;
    do_txn(1'b1, 2'd2, {4{7'b1110000}}, 0, model(1'b1, 2, {4{7'b1110000}}), "after_rst");

    for (int t = 0; t < 40; t++) begin
      p  = ($urandom_range(0, 5) != 0);
      b  = 2'($urandom);
      for (int i = 0; i < 4; i++) rr[i] = 7'($urandom);
      if (t % 5 == 0) rr = {4{7'b111_0000 | 7'($urandom_range(0, 15))}};
      ex = model(p, int'(b), rr);
      do_txn(p, b, rr, $urandom_range(0, 3), ex, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/stage2_race.md
# stage2_race

Second stage of the game engine, directly downstream of `stage1`. It accepts one stage-1 verdict per player (`pass1`, `bonus1`) through a valid/ready handshake. A qualified player then runs a multi-round race driven by a per-cycle random input, and the block reports a registered verdict (`pass2`, `score`, `bonus2`) that stays held until the consumer takes it.

## Interface
- `ROUNDS`, default 4: number of race rounds. Legal range 1..15.
- `THRESH`, default 20: minimum `score` needed for `pass2`. Legal range 0..255.

- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: a stage-1 result is present.
- `in_ready` output 1: the block can accept a result; high only in IDLE.
- `pass1` input 1: stage-1 pass flag, sampled on accept.
- `bonus1` input 2: stage-1 bonus, sampled on accept.
- `random2` input 7: race randomness, sampled once per RUN cycle.
- `out_valid` output 1: the verdict is valid; high only in DONE.
- `out_ready` input 1: the consumer takes the verdict.
- `pass2` output 1: final pass flag.
- `score` output 8: accumulated race distance.
- `bonus2` output 2: grade derived from `score`.

## Operation
- **States:** IDLE, RUN, DONE. Reset enters IDLE.
- **Reset:** clears all registers. `in_ready=1`. `out_valid`, `pass2`, `score` and `bonus2` are all 0.
- **Accept:** happens when IDLE and `in_valid`. On accept, `pass1` and `bonus1` are latched, `score` is cleared and the round counter is cleared.
  - `pass1=0`: go to DONE with `pass2=0`, `score=0`, `bonus2=0`.
  - `pass1=1`: go to RUN.
- **RUN, per cycle:**
  - Split the sample: `hi = random2[6:4]`, `stumble = random2[0]`.
  - `step = hi + bonus1_q - stumble`, floored at 0 (so it never goes negative).
  - Add `step` to `score` and increment the round counter.
  - After the `ROUNDS`-th add, go to DONE.
- **Score width:** `score` saturates at 255. The per-step value is computed at 5 bits.
- **On entering DONE from RUN:**
  - `pass2 = (score_final >= THRESH)`.
  - `bonus2` = 3 if `score_final >= THRESH+16`, 2 if `>= THRESH+8`, 1 if `>= THRESH`, else 0.
  - Compare `THRESH+n` at 9 bits so it cannot wrap.
- **DONE:** outputs are held stable. `out_valid && out_ready` returns the block to IDLE. Outputs keep their values until the next accept; only `out_valid` drops.
- **`in_valid` outside IDLE:** ignored. The upstream stage must hold its data until `in_ready`.
- **`random2` outside RUN:** ignored.

## Timing
- **Accept edge:** call it k.
- **`pass1=1` path:**
  - `random2` is sampled at edges k+1 through k+`ROUNDS`.
  - `out_valid` rises after edge k+`ROUNDS`, so latency is `ROUNDS` cycles from accept.
- **`pass1=0` path:** `out_valid` rises after edge k (1 cycle).
- **Hand-off:** `in_ready` falls after edge k. It rises again the cycle after the `out_ready` handshake edge, so there is no back-to-back overlap.
- **Output timing:** all outputs come straight from registers; there are no combinational input-to-output paths.
- **Reset mid-operation:** asserting `rst` in RUN or DONE forces IDLE asynchronously. The partial score is discarded and all outputs go to their reset values immediately.

## Configuration
- **Macro:** `STAGE2_STREAK_EN`.
- **Defined:**
  - A 1-bit register remembers whether the previous RUN round had `hi==7`.
  - A round with `hi==7` that follows such a round adds +2 to its `step`.
  - The flag clears on accept and on reset.
- **Undefined:**
  - No streak register exists.
  - `step` is exactly `hi + bonus1_q - stumble` (floored at 0).

## Test plan
All scenarios use defaults `ROUNDS=4`, `THRESH=20`.
- **Full run, strong player:** `pass1=1`, `bonus1=2`, `random2=7'b1110000` for all rounds.
  - Without streak: `score=36`, `pass2=1`, `bonus2=3`.
  - With `STAGE2_STREAK_EN`: `score=42`.
  - `out_valid` rises exactly 4 cycles after accept.
- **Stage-1 fail:** `pass1=0`, `bonus1=3` → `out_valid` 1 cycle after accept, with `pass2=0`, `score=0`, `bonus2=0`.
- **Stumble floor:** `pass1=1`, `bonus1=0`, `random2=7'b0010001` for all rounds → `score=0`, `pass2=0`, `bonus2=0`.
- **Threshold boundary:** `bonus1=0`, `random2=7'b1010000` → `score=20`, `pass2=1`, `bonus2=1`. Repeat with one round at `hi=4` → `score=19`, `pass2=0`.
- **Back-pressure:** hold `out_ready=0` for 5 cycles in DONE while pulsing `in_valid`.
  - Outputs stay unchanged and `in_ready=0` throughout.
  - Asserting `out_ready` returns to IDLE; `in_ready=1` the next cycle.
- **Reset mid-RUN:** assert `rst` after 2 rounds → all outputs go to 0 and `in_ready=1` immediately. A fresh run after release produces the full-length result.
